// File: rtl/alu_pkg.sv
// Shared constants for the registered 16-bit ALU: opcodes, compare result
// codes and the bit positions of the operation-class flag vector.
// Optional feature macro used by users of this package: ALU_DIV_EN.
package alu_pkg;

  // Operation select codes driven on ALU_FUN.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_CMPEQ = 4'd10;
  localparam logic [3:0] OP_CMPGT = 4'd11;
  localparam logic [3:0] OP_CMPLT = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_SHL  = 4'd14;
  localparam logic [3:0] OP_NOP  = 4'd15;

  // Values written to the result by the compare ops when they are true.
  localparam logic [1:0] CMP_EQ = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;
  localparam logic [1:0] CMP_LT = 2'd3;

  // Bit positions inside the 4-bit class vector {ARITH,LOGIC,CMP,SHIFT}.
  localparam int FLAG_ARITH = 3;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 1;
  localparam int FLAG_SHIFT = 0;
  localparam int FLAG_W     = 4;

endpackage

// File: rtl/alu_flag_decode.sv
// Combinational map from the ALU function code to a one-hot (or all-zero)
// operation-class vector. Depends only on the opcode, never on the result.
// Optional feature macro: ALU_DIV_EN (without it, code 3 is a NOP class).
module alu_flag_decode
  import alu_pkg::*;
(
  input  logic [3:0]        alu_fun_i,
  output logic [FLAG_W-1:0] class_o
);

  // Opcode ranges map onto classes; NOP (and DIV when not built) give zero.
  always_comb begin
    class_o = '0;
    case (alu_fun_i)
      OP_ADD, OP_SUB, OP_MUL:                          class_o[FLAG_ARITH] = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV:                                          class_o[FLAG_ARITH] = 1'b1;
`endif
      OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR: class_o[FLAG_LOGIC] = 1'b1;
      OP_CMPEQ, OP_CMPGT, OP_CMPLT:                    class_o[FLAG_CMP]   = 1'b1;
      OP_SHR, OP_SHL:                                  class_o[FLAG_SHIFT] = 1'b1;
      default:                                         class_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_reg16.sv
// Registered ALU: result and class flags are captured together at each
// rising edge, so both are valid one cycle after A/B/ALU_FUN are sampled.
// There is no handshake: a new operation is accepted every cycle and the
// outputs hold until the next edge.
// Optional feature macro: ALU_DIV_EN builds the unsigned divider for code 3;
// without it code 3 produces ALU_OUT=0 and no flags, exactly like NOP.
module alu_reg16
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             ARITH_FLAG,
  output logic             LOGIC_FLAG,
  output logic             CMP_FLAG,
  output logic             SHIFT_FLAG
);

  logic [WIDTH-1:0]  result_d, result_q;
  logic [FLAG_W-1:0] class_d, class_q;

  alu_flag_decode u_flag_decode (
    .alu_fun_i (ALU_FUN),
    .class_o   (class_d)
  );

  // Next result: every op is truncated to WIDTH; add/sub/mul in WIDTH bits
  // naturally drop the carry / wrap / keep the low half of the product.
  always_comb begin
    result_d = '0;
    case (ALU_FUN)
      OP_ADD:   result_d = A + B;
      OP_SUB:   result_d = A - B;
      OP_MUL:   result_d = A * B;
`ifdef ALU_DIV_EN
      OP_DIV:   result_d = (B == '0) ? '0 : (A / B);
`endif
      OP_AND:   result_d = A & B;
      OP_OR:    result_d = A | B;
      OP_NAND:  result_d = ~(A & B);
      OP_NOR:   result_d = ~(A | B);
      OP_XOR:   result_d = A ^ B;
      OP_XNOR:  result_d = ~(A ^ B);
      OP_CMPEQ: result_d = (A == B) ? {{(WIDTH-2){1'b0}}, CMP_EQ} : '0;
      OP_CMPGT: result_d = (A > B)  ? {{(WIDTH-2){1'b0}}, CMP_GT} : '0;
      OP_CMPLT: result_d = (A < B)  ? {{(WIDTH-2){1'b0}}, CMP_LT} : '0;
      OP_SHR:   result_d = {1'b0, A[WIDTH-1:1]};
      OP_SHL:   result_d = {A[WIDTH-2:0], 1'b0};
      default:  result_d = '0;
    endcase
  end

  // Capture result and class together; reset wins over any pending op.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      class_q  <= '0;
    end else begin
      result_q <= result_d;
      class_q  <= class_d;
    end
  end

  assign ALU_OUT    = result_q;
  assign ARITH_FLAG = class_q[FLAG_ARITH];
  assign LOGIC_FLAG = class_q[FLAG_LOGIC];
  assign CMP_FLAG   = class_q[FLAG_CMP];
  assign SHIFT_FLAG = class_q[FLAG_SHIFT];

endmodule

// File: tb/tb_alu_reg16.sv
// Directed bench for alu_reg16 with hand-computed expected values.
// Follows ALU_DIV_EN so the code-3 expectations match the build.
module tb_alu_reg16;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_fun;
  logic [W-1:0] alu_out;
  logic         arith_flag, logic_flag, cmp_flag, shift_flag;

  int n_checks;
  int n_fail;

  // Scoreboard: expected result and expected {ARITH,LOGIC,CMP,SHIFT}.
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_flag_q[$];

  alu_reg16 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (a),
    .B          (b),
    .ALU_FUN    (alu_fun),
    .ALU_OUT    (alu_out),
    .ARITH_FLAG (arith_flag),
    .LOGIC_FLAG (logic_flag),
    .CMP_FLAG   (cmp_flag),
    .SHIFT_FLAG (shift_flag)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Drive one op (with rst level) at the falling edge, queue the expectation,
  // then sample just after the next rising edge and compare.
  task automatic drive_op(input string tag, input logic r, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [3:0] fun,
                          input logic [W-1:0] exp_out, input logic [3:0] exp_flags);
    logic [W-1:0] e_out;
    logic [3:0]   e_flg;
    @(negedge clk);
    rst     = r;
    a       = av;
    b       = bv;
    alu_fun = fun;
    exp_q.push_back(exp_out);
    exp_flag_q.push_back(exp_flags);
    @(posedge clk);
    #1;
    e_out = exp_q.pop_front();
    e_flg = exp_flag_q.pop_front();
    check_eq({tag, " out"}, alu_out, e_out);
    check_eq({tag, " flags"}, {12'd0, arith_flag, logic_flag, cmp_flag, shift_flag}, {12'd0, e_flg});
  endtask

  localparam logic [W-1:0] OA = 16'h00A2;
  localparam logic [W-1:0] OB = 16'h0055;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; a = '0; b = '0; alu_fun = 4'd0;

    // Reset state
    drive_op("reset", 1'b1, OA, OB, 4'd5, 16'd0, 4'b0000);

    // Arithmetic
    drive_op("add", 1'b0, OA, OB, 4'd0, 16'd247,   4'b1000);
    drive_op("sub", 1'b0, OA, OB, 4'd1, 16'd77,    4'b1000);
    drive_op("mul", 1'b0, OA, OB, 4'd2, 16'd13770, 4'b1000);
`ifdef ALU_DIV_EN
    drive_op("div", 1'b0, OA, OB, 4'd3, 16'd1,     4'b1000);
`else
    drive_op("div_off", 1'b0, OA, OB, 4'd3, 16'd0, 4'b0000);
`endif

    // Logic
    drive_op("and",  1'b0, OA, OB, 4'd4, 16'd0,     4'b0100);
    drive_op("or",   1'b0, OA, OB, 4'd5, 16'd247,   4'b0100);
    drive_op("nand", 1'b0, OA, OB, 4'd6, 16'd65535, 4'b0100);
    drive_op("nor",  1'b0, OA, OB, 4'd7, 16'd65288, 4'b0100);
    drive_op("xor",  1'b0, OA, OB, 4'd8, 16'd247,   4'b0100);
    drive_op("xnor", 1'b0, OA, OB, 4'd9, 16'd65288, 4'b0100);

    // Compare
    drive_op("cmp_eq_f", 1'b0, OA, OB, 4'd10, 16'd0, 4'b0010);
    drive_op("cmp_gt",   1'b0, OA, OB, 4'd11, 16'd2, 4'b0010);
    drive_op("cmp_lt_f", 1'b0, OA, OB, 4'd12, 16'd0, 4'b0010);
    drive_op("cmp_eq_t", 1'b0, 16'h1234, 16'h1234, 4'd10, 16'd1, 4'b0010);
    drive_op("cmp_lt_t", 1'b0, OB, OA, 4'd12, 16'd3, 4'b0010);
    drive_op("cmp_gt_f", 1'b0, OB, OA, 4'd11, 16'd0, 4'b0010);

    // Shift
    drive_op("shr", 1'b0, OA, OB, 4'd13, 16'd81,  4'b0001);
    drive_op("shl", 1'b0, OA, OB, 4'd14, 16'd324, 4'b0001);
    drive_op("shr_msb", 1'b0, 16'h8001, OB, 4'd13, 16'h4000, 4'b0001);

    // Edge cases
    drive_op("sub_wrap", 1'b0, 16'h0000, 16'h0001, 4'd1, 16'hFFFF, 4'b1000);
    drive_op("mul_wrap", 1'b0, 16'hFFFF, 16'hFFFF, 4'd2, 16'h0001, 4'b1000);
    drive_op("add_carry", 1'b0, 16'hFFFF, 16'h0002, 4'd0, 16'h0001, 4'b1000);
`ifdef ALU_DIV_EN
    drive_op("div_zero", 1'b0, OA, 16'h0000, 4'd3, 16'd0, 4'b1000);
    drive_op("div_big",  1'b0, 16'hFFFF, 16'h0010, 4'd3, 16'h0FFF, 4'b1000);
`else
    drive_op("div_zero_off", 1'b0, OA, 16'h0000, 4'd3, 16'd0, 4'b0000);
`endif
    drive_op("shl_msb", 1'b0, 16'h8000, OB, 4'd14, 16'd0, 4'b0001);

    // NOP
    drive_op("nop", 1'b0, OA, OB, 4'd15, 16'd0, 4'b0000);

    // Reset while an add is presented, then release
    drive_op("add_pre", 1'b0, OA, OB, 4'd0, 16'd247, 4'b1000);
    drive_op("rst_mid", 1'b1, OA, OB, 4'd0, 16'd0,   4'b0000);
    drive_op("rst_rel", 1'b0, OA, OB, 4'd0, 16'd247, 4'b1000);

    // Back-to-back ops change every cycle
    drive_op("b2b_xor", 1'b0, 16'hFF00, 16'h0FF0, 4'd8, 16'hF0F0, 4'b0100);
    drive_op("b2b_and", 1'b0, 16'hFF00, 16'h0FF0, 4'd4, 16'h0F00, 4'b0100);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
